// File: rtl/updown_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module      : updown_cmd_gen
// Description : Turns two raw push buttons (up/down) into single-cycle count
//               commands (enable + direction) for an up/down counter.
//               Synchronises and debounces each button, auto-repeats while a
//               button is held, and rejects simultaneous presses (conflict).
// Revision    : 1.0 - initial release
// ============================================================================
module updown_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  output logic enable,
  output logic direction,
  output logic conflict
);

  localparam int c_db_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_tmr_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_tmr_w   = $clog2(c_tmr_max);

  // The debounced level flips on the edge where the counter would reach
  // DEBOUNCE_CYCLES, so compare against one less.
  localparam logic [c_db_w-1:0]  c_db_last     = c_db_w'(DEBOUNCE_CYCLES - 1);
  // The timer counts down to zero; zero is the edge the pulse is registered.
  localparam logic [c_tmr_w-1:0] c_delay_load  = c_tmr_w'(REPEAT_DELAY - 1);
  localparam logic [c_tmr_w-1:0] c_period_load = c_tmr_w'(REPEAT_PERIOD - 1);

  // Bit 1 = up button, bit 0 = down button throughout.
  logic [1:0]             sync1_q, sync1_d;
  logic [1:0]             sync2_q, sync2_d;
  logic [1:0]             deb_q, deb_d;
  logic [1:0][c_db_w-1:0] db_cnt_q, db_cnt_d;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_BLOCK  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [c_tmr_w-1:0]   timer_q, timer_d;
  logic                 enable_q, enable_d;
  logic                 direction_q, direction_d;
  logic                 conflict_q, conflict_d;

  logic up_lvl;
  logic dn_lvl;
  logic act_lvl;
  logic oth_lvl;

  assign up_lvl  = deb_q[1];
  assign dn_lvl  = deb_q[0];
  // While repeating, the active button is the one the direction latched.
  assign act_lvl = direction_q ? up_lvl : dn_lvl;
  assign oth_lvl = direction_q ? dn_lvl : up_lvl;

  // Synchroniser shift and per-button debounce counters.
  always_comb begin
    sync1_d  = {btn_up, btn_down};
    sync2_d  = sync1_q;
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == c_db_last) begin
        deb_d[i]    = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + c_db_w'(1);
      end
    end
  end

  // Input-side registers: synchroniser stages, debounced levels, counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      deb_q    <= deb_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Next-state, repeat timer and registered-output values of the command FSM.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    enable_d    = 1'b0;
    direction_d = direction_q;
    case (state_q)
      ST_IDLE: begin
        if (up_lvl && dn_lvl) begin
          state_d = ST_BLOCK;
        end else if (up_lvl || dn_lvl) begin
          enable_d    = 1'b1;
          direction_d = up_lvl;
          timer_d     = c_delay_load;
          state_d     = ST_DELAY;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        // Release beats conflict, conflict beats a pulse due this cycle.
        if (!act_lvl) begin
          state_d = ST_IDLE;
        end else if (oth_lvl) begin
          state_d = ST_BLOCK;
        end else if (timer_q == '0) begin
          enable_d = 1'b1;
          timer_d  = c_period_load;
          state_d  = ST_REPEAT;
        end else begin
          timer_d = timer_q - c_tmr_w'(1);
        end
      end
      ST_BLOCK: begin
        if (!up_lvl && !dn_lvl) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    conflict_d = (state_d == ST_BLOCK);
  end

  // FSM state, timer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      enable_q    <= 1'b0;
      direction_q <= 1'b1;
      conflict_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      enable_q    <= enable_d;
      direction_q <= direction_d;
      conflict_q  <= conflict_d;
    end
  end

  assign enable    = enable_q;
  assign direction = direction_q;
  assign conflict  = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_updown_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_cmd_gen
// Description : Scoreboard bench for updown_cmd_gen. Stimulus pushes the
//               expected (cycle, direction) of every enable pulse; a monitor
//               pops and compares each pulse the DUT produces.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_cmd_gen;

  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst;
  logic btn_up;
  logic btn_down;
  logic enable;
  logic direction;
  logic conflict;

  // Number of rising edges seen so far.
  int ecnt  = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int   cyc;
    logic dir;
  } exp_t;

  exp_t exp_q[$];

  updown_cmd_gen #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .enable   (enable),
    .direction(direction),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  // Monitor: every enable pulse must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (enable === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pulse: unexpected enable at cycle %0d dir %0b, none required", ecnt, direction);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != ecnt || e.dir !== direction) begin
          n_bad++;
          $display("FAIL pulse: got cycle %0d dir %0b, required cycle %0d dir %0b",
                   ecnt, direction, e.cyc, e.dir);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic got, input logic req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  task automatic chk_empty(input string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d pulses still outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic push(input int cyc, input logic dir);
    exp_t e;
    e.cyc = cyc;
    e.dir = dir;
    exp_q.push_back(e);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    int s;

    // Reset with both buttons held.
    rst = 1'b1; btn_up = 1'b1; btn_down = 1'b1;
    tick(1); @(negedge clk);
    chk("rst_en_1", enable, 1'b0);
    chk("rst_dir_1", direction, 1'b1);
    chk("rst_cf_1", conflict, 1'b0);
    tick(1); @(negedge clk);
    chk("rst_en_2", enable, 1'b0);
    chk("rst_dir_2", direction, 1'b1);
    chk("rst_cf_2", conflict, 1'b0);
    rst = 1'b0;
    tick(1); @(negedge clk);
    chk("post_rst_en", enable, 1'b0);
    chk("post_rst_dir", direction, 1'b1);
    chk("post_rst_cf", conflict, 1'b0);
    // Both debounce together: conflict without any pulse.
    tick(7); @(negedge clk);
    chk("both_held_cf", conflict, 1'b1);
    btn_up = 1'b0; btn_down = 1'b0;
    tick(10); @(negedge clk);
    chk("both_rel_cf", conflict, 1'b0);
    chk_empty("both_held_pulses");

    // Short up press: released before the first repeat could fall due.
    k = ecnt;
    btn_up = 1'b1;
    push(k + 7, 1'b1);
    tick(6);
    btn_up = 1'b0;
    tick(20); @(negedge clk);
    chk_empty("short_press");
    chk("short_dir", direction, 1'b1);

    // Bouncy down input: high pulses only 2 cycles long.
    repeat (3) begin
      btn_down = 1'b1; tick(2);
      btn_down = 1'b0; tick(2);
    end
    tick(10); @(negedge clk);
    chk_empty("bounce");
    chk("bounce_dir", direction, 1'b1);

    // Down held 30 cycles: pulses at sampling edges 6, 14, 17, ... 35.
    k = ecnt;
    btn_down = 1'b1;
    push(k + 1 + 6, 1'b0);
    s = 6 + RD;
    while (s <= 35) begin
      push(k + 1 + s, 1'b0);
      s += RP;
    end
    tick(30);
    btn_down = 1'b0;
    tick(20); @(negedge clk);
    chk_empty("hold_down");
    chk("hold_dir", direction, 1'b0);

    // Conflict: down arrives exactly as the first up repeat falls due.
    k = ecnt;
    btn_up = 1'b1;
    push(k + 7, 1'b1);
    tick(8);
    btn_down = 1'b1;
    tick(8); @(negedge clk);
    chk("conflict_set", conflict, 1'b1);
    tick(4);
    btn_down = 1'b0;
    tick(14); @(negedge clk);
    chk("conflict_up_only", conflict, 1'b1);
    btn_up = 1'b0;
    tick(10); @(negedge clk);
    chk("conflict_clear", conflict, 1'b0);
    chk_empty("conflict_pulses");
    chk("conflict_dir", direction, 1'b1);
    k = ecnt;
    btn_up = 1'b1;
    push(k + 7, 1'b1);
    tick(6);
    btn_up = 1'b0;
    tick(20); @(negedge clk);
    chk_empty("fresh_press");

    // Reset between repeats cancels the pulse due at sampling edge 20.
    btn_down = 1'b1;
    tick(2);
    btn_down = 1'b0;
    tick(10);
    k = ecnt;
    btn_up = 1'b1;
    push(k + 7, 1'b1);
    push(k + 15, 1'b1);
    push(k + 18, 1'b1);
    tick(18);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_en", enable, 1'b0);
    chk("mid_rst_cf", conflict, 1'b0);
    chk("mid_rst_dir", direction, 1'b1);
    push(k + 26, 1'b1);
    tick(7);
    btn_up = 1'b0;
    tick(20); @(negedge clk);
    chk_empty("reset_repeat");
    chk("final_cf", conflict, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
